// File: rtl/pdu_input_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_input_cond_pkg
//  Description : Shared constants and channel indices for the PDU input
//                conditioning block (board buttons and slide switches).
//  Revision    : 1.0 - initial release
// ============================================================================
package pdu_input_cond_pkg;

    // Channel counts on the board
    localparam int c_NUM_BTN = 5;
    localparam int c_NUM_SW  = 16;

    // Default debounce window: 10 ms at 100 MHz, and a counter wide enough for it
    localparam int c_DB_CYCLES_DFLT = 1_000_000;
    localparam int c_CNT_W_DFLT     = 20;

    // Bit positions of the push-buttons inside the packed button vector
    typedef enum logic [2:0] {
        BTN_DEL  = 3'd0,
        BTN_ENT  = 3'd1,
        BTN_CHK  = 3'd2,
        BTN_CONT = 3'd3,
        BTN_STEP = 3'd4
    } btn_idx_e;

endpackage : pdu_input_cond_pkg
`default_nettype wire

// File: rtl/pdu_db_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_db_chan
//  Description : One input channel: 2-FF synchroniser, stability counter,
//                debounced level with post-reset arming, and a registered
//                single-cycle pulse on accepted edges (rising only, or both
//                directions when BOTH_EDGES is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module pdu_db_chan
    import pdu_input_cond_pkg::*;
#(
    parameter int DB_CYCLES  = c_DB_CYCLES_DFLT,
    parameter int CNT_W      = c_CNT_W_DFLT,
    parameter bit BOTH_EDGES = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic pulse
);

    // Terminal count: the sample has differed for DB_CYCLES consecutive edges
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_cand;
    logic             r_valid;
    logic             r_evt;
    logic             r_pulse;

    logic             w_s;
    logic             w_count;
    logic             w_done;

    // Two-stage synchroniser for the asynchronous board pin
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Once armed, count while the sample disagrees with the level; before
    // arming, count while the sample matches the current arming candidate.
    always_comb begin
        w_s     = r_sync2;
        w_count = r_valid ? (w_s != r_level) : (w_s == r_cand);
        w_done  = w_count && (r_cnt == c_CNT_MAX);
    end

    // Debounce counter, level, arming candidate and valid flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_cand  <= 1'b0;
            r_valid <= 1'b0;
        end else if (!r_valid && (w_s != r_cand)) begin
            // Unarmed and the input moved: restart the arming window on the new value
            r_cand <= w_s;
            r_cnt  <= '0;
        end else if (w_done) begin
            r_level <= w_s;
            r_valid <= 1'b1;
            r_cnt   <= '0;
        end else if (w_count) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Edge event at acceptance, then the output pulse one cycle later;
    // the arming acceptance never produces an event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_evt   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_evt   <= w_done && r_valid && (BOTH_EDGES || w_s);
            r_pulse <= r_evt;
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule : pdu_db_chan
`default_nettype wire

// File: rtl/pdu_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_input_cond
//  Description : Conditions the raw board buttons and slide switches for the
//                PDU control FSM: every channel is synchronised, debounced and
//                turned into a single-cycle pulse. Buttons pulse on press only;
//                switches pulse on either toggle direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdu_input_cond
    import pdu_input_cond_pkg::*;
#(
    parameter int DB_CYCLES = c_DB_CYCLES_DFLT,
    parameter int CNT_W     = c_CNT_W_DFLT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                step,
    input  logic                cont,
    input  logic                chk,
    input  logic                ent,
    input  logic                del,
    input  logic [c_NUM_SW-1:0] hd,
    output logic                step_ps,
    output logic                cont_ps,
    output logic                chk_ps,
    output logic                ent_ps,
    output logic                del_ps,
    output logic [c_NUM_SW-1:0] hd_ps,
    output logic [c_NUM_SW-1:0] hd_lvl
);

    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] w_btn_ps;
    logic [c_NUM_BTN-1:0] w_btn_lvl_unused;

    // Gather the named buttons into one vector so they share a generate loop
    always_comb begin
        w_btn_raw           = '0;
        w_btn_raw[BTN_STEP] = step;
        w_btn_raw[BTN_CONT] = cont;
        w_btn_raw[BTN_CHK]  = chk;
        w_btn_raw[BTN_ENT]  = ent;
        w_btn_raw[BTN_DEL]  = del;
    end

    // Buttons: press-only pulses; the debounced level is not consumed upstream
    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
            pdu_db_chan #(
                .DB_CYCLES  (DB_CYCLES),
                .CNT_W      (CNT_W),
                .BOTH_EDGES (1'b0)
            ) u_chan (
                .clk   (clk),
                .rstn  (rstn),
                .raw   (w_btn_raw[gi]),
                .level (w_btn_lvl_unused[gi]),
                .pulse (w_btn_ps[gi])
            );
        end
    endgenerate

    // Switches: pulse on every accepted toggle, level exported
    generate
        for (genvar gi = 0; gi < c_NUM_SW; gi++) begin : g_sw
            pdu_db_chan #(
                .DB_CYCLES  (DB_CYCLES),
                .CNT_W      (CNT_W),
                .BOTH_EDGES (1'b1)
            ) u_chan (
                .clk   (clk),
                .rstn  (rstn),
                .raw   (hd[gi]),
                .level (hd_lvl[gi]),
                .pulse (hd_ps[gi])
            );
        end
    endgenerate

    assign step_ps = w_btn_ps[BTN_STEP];
    assign cont_ps = w_btn_ps[BTN_CONT];
    assign chk_ps  = w_btn_ps[BTN_CHK];
    assign ent_ps  = w_btn_ps[BTN_ENT];
    assign del_ps  = w_btn_ps[BTN_DEL];

endmodule : pdu_input_cond
`default_nettype wire

// File: tb/tb_pdu_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdu_input_cond
//  Description : Directed bench for pdu_input_cond with a short debounce
//                window. Expected pulse vectors are queued with their due
//                cycle when stimulus is applied and compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdu_input_cond;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    // Packed observation vector: {step, cont, chk, ent, del, hd[15:0]}
    localparam logic [20:0] B_DEL  = 21'h1 << 16;
    localparam logic [20:0] B_ENT  = 21'h1 << 17;
    localparam logic [20:0] B_CHK  = 21'h1 << 18;

    logic        clk;
    logic        rstn;
    logic        step, cont, chk, ent, del;
    logic [15:0] hd;
    logic        step_ps, cont_ps, chk_ps, ent_ps, del_ps;
    logic [15:0] hd_ps;
    logic [15:0] hd_lvl;

    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        int unsigned cyc;
        logic [20:0] v;
    } exp_t;
    exp_t        sb[$];
    logic [20:0] chk_exp;
    logic [20:0] obs;

    pdu_input_cond #(
        .DB_CYCLES (DB),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .step    (step),
        .cont    (cont),
        .chk     (chk),
        .ent     (ent),
        .del     (del),
        .hd      (hd),
        .step_ps (step_ps),
        .cont_ps (cont_ps),
        .chk_ps  (chk_ps),
        .ent_ps  (ent_ps),
        .del_ps  (del_ps),
        .hd_ps   (hd_ps),
        .hd_lvl  (hd_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {step_ps, cont_ps, chk_ps, ent_ps, del_ps, hd_ps};

    // Queue an expected pulse vector due LAT edges after the current cycle
    task automatic push(input logic [20:0] v);
        sb.push_back('{cyc: cyc + LAT, v: v});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Every cycle: pulses must equal whatever is due now, otherwise all zero
    always @(negedge clk) begin
        chk_exp = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk_exp = chk_exp | sb[0].v;
            void'(sb.pop_front());
        end
        total++;
        assert (obs === chk_exp) else begin
            bad++;
            $error("FAIL pulses cyc=%0d observed=%h expected=%h", cyc, obs, chk_exp);
        end
    end

    initial begin
        // 1: arming with a switch pattern and a button held through reset
        rstn = 1'b0;
        step = 1'b1; cont = 1'b0; chk = 1'b0; ent = 1'b0; del = 1'b0;
        hd   = 16'h0005;
        wait_cyc(3);
        check("rst_lvl", 32'(hd_lvl), 32'h0);
        rstn = 1'b1;
        wait_cyc(20);
        check("arm_lvl", 32'(hd_lvl), 32'h0005);
        step = 1'b0;
        wait_cyc(20);

        // 2: clean press, release without pulse, second press
        ent = 1'b1; push(B_ENT);
        wait_cyc(20);
        ent = 1'b0;
        wait_cyc(20);
        ent = 1'b1; push(B_ENT);
        wait_cyc(20);
        ent = 1'b0;
        wait_cyc(20);

        // 3: bounce train then a steady press; then a lone 3-cycle glitch
        for (int i = 0; i < 4; i++) begin
            del = (i % 2 == 0);
            wait_cyc(2);
        end
        del = 1'b1; push(B_DEL);
        wait_cyc(20);
        del = 1'b0;
        wait_cyc(20);
        del = 1'b1;
        wait_cyc(3);
        del = 1'b0;
        wait_cyc(20);

        // 4: switch toggles in both directions
        hd[9] = 1'b1; push(21'h0200);
        wait_cyc(20);
        check("sw9_up_lvl", 32'(hd_lvl), 32'h0205);
        hd[9] = 1'b0; push(21'h0200);
        wait_cyc(20);
        check("sw9_dn_lvl", 32'(hd_lvl), 32'h0005);

        // 5: simultaneous events on two switches and a button
        hd[3] = 1'b1; hd[12] = 1'b1; chk = 1'b1;
        push(B_CHK | 21'h1008);
        wait_cyc(20);
        check("simul_lvl", 32'(hd_lvl), 32'h100D);
        chk = 1'b0;
        wait_cyc(20);

        // 6: reset in the middle of a debounce window
        hd[0] = 1'b0; push(21'h0001);
        wait_cyc(20);
        check("sw0_dn_lvl", 32'(hd_lvl), 32'h100C);
        hd[0] = 1'b1;
        wait_cyc(2);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_lvl", 32'(hd_lvl), 32'h0);
        check("async_rst_ps", 32'(obs), 32'h0);
        wait_cyc(2);
        rstn = 1'b1;
        wait_cyc(20);
        check("rearm_lvl", 32'(hd_lvl), 32'h100D);

        wait_cyc(5);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pdu_input_cond
`default_nettype wire
